// File: rtl/cpu_run_controller_if.sv
// Host command/response channel of the run controller: one valid/ready command path
// and one valid/ready response path.
interface cpu_run_controller_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_op;
   logic [4:0]  cmd_addr;
   logic [31:0] cmd_data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_err;

   modport master (
      output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/cpu_run_controller.sv
// Run/halt/step sequencer and debug-access port for the rv32i core: stalls the core at
// instruction boundaries, single-steps, accesses PC/GPRs while halted, one PC breakpoint.
module cpu_run_controller #(
   parameter int HALT_ON_RESET  = 1,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                 CLK,
   input  logic                 RST,
   cpu_run_controller_if.slave  host,
   input  logic                 core_pc_fire,
   input  logic                 core_idle,
   output logic                 cm_pc_stall,
   input  logic [31:0]          cm_pc_read_data,
   output logic                 cm_pc_we,
   output logic [31:0]          cm_pc_write_data,
   output logic [4:0]           cm_regfile_addr,
   input  logic [31:0]          cm_regfile_read_data,
   output logic                 cm_regfile_we,
   output logic [31:0]          cm_regfile_write_data
);

   typedef enum logic [2:0] {
      S_RUNNING, S_HALTING, S_HALTED, S_STEP_RUN, S_STEP_DRAIN, S_ACCESS, S_RESP
   } state_t;

   localparam state_t RESET_STATE = (HALT_ON_RESET != 0) ? S_HALTED : S_RUNNING;
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

   localparam logic [3:0] OP_STATUS = 4'd0;
   localparam logic [3:0] OP_HALT   = 4'd1;
   localparam logic [3:0] OP_RESUME = 4'd2;
   localparam logic [3:0] OP_STEP   = 4'd3;
   localparam logic [3:0] OP_RD_PC  = 4'd4;
   localparam logic [3:0] OP_WR_PC  = 4'd5;
   localparam logic [3:0] OP_RD_REG = 4'd6;
   localparam logic [3:0] OP_WR_REG = 4'd7;
   localparam logic [3:0] OP_SET_BP = 4'd8;
   localparam logic [3:0] OP_CLR_BP = 4'd9;

   state_t        state, state_nxt, ret_state, ret_nxt;
   logic [3:0]    acc_op, acc_op_nxt;
   logic          rsp_valid_q, rsp_valid_nxt;
   logic [31:0]   rsp_data_q, rsp_data_nxt;
   logic          rsp_err_q, rsp_err_nxt;
   logic          pc_we_nxt, rf_we_nxt;
   logic [31:0]   pc_wdata_nxt, rf_wdata_nxt;
   logic [4:0]    rf_addr_nxt;
   logic          bp_en, bp_en_nxt;
   logic [31:0]   bp_addr, bp_addr_nxt;
   logic          skip_bp, skip_bp_nxt;
   logic [TW-1:0] timer, timer_nxt;
   logic          cmd_fire, bp_hit, is_halted;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state                 <= RESET_STATE;
         ret_state             <= RESET_STATE;
         acc_op                <= OP_STATUS;
         rsp_valid_q           <= 1'b0;
         rsp_data_q            <= '0;
         rsp_err_q             <= 1'b0;
         cm_pc_we              <= 1'b0;
         cm_pc_write_data      <= '0;
         cm_regfile_we         <= 1'b0;
         cm_regfile_addr       <= '0;
         cm_regfile_write_data <= '0;
         bp_en                 <= 1'b0;
         bp_addr               <= '0;
         skip_bp               <= 1'b0;
         timer                 <= '0;
      end else begin
         state                 <= state_nxt;
         ret_state             <= ret_nxt;
         acc_op                <= acc_op_nxt;
         rsp_valid_q           <= rsp_valid_nxt;
         rsp_data_q            <= rsp_data_nxt;
         rsp_err_q             <= rsp_err_nxt;
         cm_pc_we              <= pc_we_nxt;
         cm_pc_write_data      <= pc_wdata_nxt;
         cm_regfile_we         <= rf_we_nxt;
         cm_regfile_addr       <= rf_addr_nxt;
         cm_regfile_write_data <= rf_wdata_nxt;
         bp_en                 <= bp_en_nxt;
         bp_addr               <= bp_addr_nxt;
         skip_bp               <= skip_bp_nxt;
         timer                 <= timer_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      ret_nxt       = ret_state;
      acc_op_nxt    = acc_op;
      rsp_data_nxt  = rsp_data_q;
      rsp_err_nxt   = rsp_err_q;
      pc_we_nxt     = 1'b0;
      pc_wdata_nxt  = cm_pc_write_data;
      rf_we_nxt     = 1'b0;
      rf_addr_nxt   = cm_regfile_addr;
      rf_wdata_nxt  = cm_regfile_write_data;
      bp_en_nxt     = bp_en;
      bp_addr_nxt   = bp_addr;
      skip_bp_nxt   = core_pc_fire ? 1'b0 : skip_bp;
      timer_nxt     = timer;

      case (state)
         S_RUNNING, S_HALTED: begin
            if (cmd_fire) begin
               // Every accepted command ends in RESP; ret_nxt picks where RESP releases to.
               state_nxt    = S_RESP;
               ret_nxt      = state;
               rsp_data_nxt = '0;
               rsp_err_nxt  = 1'b0;
               case (host.cmd_op)
                  OP_STATUS: rsp_data_nxt = {29'b0, bp_en, is_halted, (state == S_RUNNING)};
                  OP_HALT: begin
                     if (!is_halted) begin
                        state_nxt = S_HALTING;
                        timer_nxt = '0;
                     end
                  end
                  OP_RESUME: begin
                     ret_nxt = S_RUNNING;
                     if (is_halted) skip_bp_nxt = 1'b1;
                  end
                  OP_STEP: begin
                     if (is_halted) begin
                        state_nxt   = S_STEP_RUN;
                        skip_bp_nxt = 1'b1;
                        timer_nxt   = '0;
                     end else begin
                        rsp_err_nxt = 1'b1;
                     end
                  end
                  OP_RD_PC, OP_WR_PC, OP_RD_REG, OP_WR_REG: begin
                     if (is_halted) begin
                        state_nxt  = S_ACCESS;
                        acc_op_nxt = host.cmd_op;
                        if (host.cmd_op == OP_RD_REG || host.cmd_op == OP_WR_REG)
                           rf_addr_nxt = host.cmd_addr;
                        if (host.cmd_op == OP_WR_PC) begin
                           pc_we_nxt    = 1'b1;
                           pc_wdata_nxt = host.cmd_data;
                        end
                        if (host.cmd_op == OP_WR_REG) begin
                           rf_we_nxt    = 1'b1;
                           rf_wdata_nxt = host.cmd_data;
                        end
                     end else begin
                        rsp_err_nxt = 1'b1;
                     end
                  end
                  OP_SET_BP: begin
                     bp_en_nxt   = 1'b1;
                     bp_addr_nxt = host.cmd_data;
                  end
                  OP_CLR_BP: bp_en_nxt = 1'b0;
                  default:   rsp_err_nxt = 1'b1;
               endcase
            end else if (state == S_RUNNING && bp_hit && !skip_bp && core_idle) begin
               state_nxt = S_HALTED;
            end
         end
         S_HALTING, S_STEP_RUN, S_STEP_DRAIN: begin
            if (state == S_STEP_RUN && core_pc_fire) begin
               state_nxt = S_STEP_DRAIN;
               timer_nxt = '0;
            end else if (state != S_STEP_RUN && core_idle) begin
               state_nxt    = S_RESP;
               ret_nxt      = S_HALTED;
               rsp_data_nxt = '0;
               rsp_err_nxt  = 1'b0;
            end else if (timer == TIMER_LAST) begin
               // A halt that never drains leaves the core running; a stuck step stays halted.
               state_nxt    = S_RESP;
               ret_nxt      = (state == S_HALTING) ? S_RUNNING : S_HALTED;
               rsp_data_nxt = '0;
               rsp_err_nxt  = 1'b1;
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end
         S_ACCESS: begin
            state_nxt    = S_RESP;
            ret_nxt      = S_HALTED;
            rsp_err_nxt  = 1'b0;
            rsp_data_nxt = (acc_op == OP_RD_PC)  ? cm_pc_read_data :
                           (acc_op == OP_RD_REG) ? cm_regfile_read_data : 32'h0;
         end
         S_RESP: begin
            if (host.rsp_ready) state_nxt = ret_state;
         end
         default: state_nxt = RESET_STATE;
      endcase

      rsp_valid_nxt = (state_nxt == S_RESP);
   end

   always_comb begin
      is_halted      = (state == S_HALTED);
      host.cmd_ready = (state == S_RUNNING || state == S_HALTED) && !rsp_valid_q;
      cmd_fire       = host.cmd_valid && host.cmd_ready;
      bp_hit         = bp_en && (cm_pc_read_data == bp_addr);
      cm_pc_stall    = (state != S_RUNNING && state != S_STEP_RUN) || (bp_hit && !skip_bp);
      host.rsp_valid = rsp_valid_q;
      host.rsp_data  = rsp_data_q;
      host.rsp_err   = rsp_err_q;
   end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller with a tiny single-issue core model behind it.
`timescale 1ns/1ps
module tb_cpu_run_controller;

   localparam int TMO = 16;

   logic        CLK, RST;
   logic        core_pc_fire, core_idle, cm_pc_stall;
   logic [31:0] cm_pc_read_data, cm_pc_write_data;
   logic        cm_pc_we, cm_regfile_we;
   logic [4:0]  cm_regfile_addr;
   logic [31:0] cm_regfile_read_data, cm_regfile_write_data;

   cpu_run_controller_if cif ();

   cpu_run_controller #(.HALT_ON_RESET(1), .TIMEOUT_CYCLES(TMO)) dut (
      .CLK(CLK), .RST(RST), .host(cif),
      .core_pc_fire(core_pc_fire), .core_idle(core_idle), .cm_pc_stall(cm_pc_stall),
      .cm_pc_read_data(cm_pc_read_data), .cm_pc_we(cm_pc_we), .cm_pc_write_data(cm_pc_write_data),
      .cm_regfile_addr(cm_regfile_addr), .cm_regfile_read_data(cm_regfile_read_data),
      .cm_regfile_we(cm_regfile_we), .cm_regfile_write_data(cm_regfile_write_data)
   );

   int checks = 0;
   int errors = 0;

   // Core model: fetches only when nothing is in flight, each instruction takes 2 cycles.
   logic [31:0] core_pc;
   logic [1:0]  in_flight;
   logic [31:0] regs [32];
   logic        hold_busy, block_fire;
   int          fire_cnt = 0, rf_we_cnt = 0, pc_we_cnt = 0;

   assign core_pc_fire         = (in_flight == 2'd0) && !block_fire && !cm_pc_stall;
   assign core_idle            = (in_flight == 2'd0) && !hold_busy;
   assign cm_pc_read_data      = core_pc;
   assign cm_regfile_read_data = (cm_regfile_addr == 5'd0) ? 32'h0 : regs[cm_regfile_addr];

   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         core_pc   <= 32'h100;
         in_flight <= 2'd0;
      end else begin
         if (cm_pc_we)          core_pc <= cm_pc_write_data;
         else if (core_pc_fire) core_pc <= core_pc + 32'd4;
         if (core_pc_fire)           in_flight <= 2'd2;
         else if (in_flight != 2'd0) in_flight <= in_flight - 2'd1;
      end
   end

   always @(posedge CLK) begin
      if (cm_regfile_we && cm_regfile_addr != 5'd0) regs[cm_regfile_addr] <= cm_regfile_write_data;
      if (core_pc_fire)  fire_cnt  <= fire_cnt + 1;
      if (cm_regfile_we) rf_we_cnt <= rf_we_cnt + 1;
      if (cm_pc_we)      pc_we_cnt <= pc_we_cnt + 1;
   end

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Drives one command and collects its response; lat counts cycles from accept to rsp_valid.
   task automatic do_cmd(input logic [3:0] op, input logic [4:0] addr, input logic [31:0] data,
                         output logic [31:0] rdata, output logic rerr, output int lat);
      int n;
      rdata = 'x;
      rerr  = 1'bx;
      lat   = -1;
      @(negedge CLK);
      cif.cmd_valid = 1'b1;
      cif.cmd_op    = op;
      cif.cmd_addr  = addr;
      cif.cmd_data  = data;
      n = 0;
      while (!cif.cmd_ready && n < 200) begin
         @(negedge CLK);
         n++;
      end
      if (!cif.cmd_ready) begin
         checks++; errors++;
         $display("[TB] FAIL cmd_accept op=%0d: cmd_ready stayed 0, required 1", op);
         cif.cmd_valid = 1'b0;
         return;
      end
      @(posedge CLK);
      #1 cif.cmd_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge CLK);
         lat++;
      end while (!cif.rsp_valid && lat < 200);
      if (!cif.rsp_valid) begin
         checks++; errors++;
         $display("[TB] FAIL rsp_wait op=%0d: rsp_valid stayed 0, required 1", op);
         lat = -1;
         return;
      end
      rdata = cif.rsp_data;
      rerr  = cif.rsp_err;
      cif.rsp_ready = 1'b1;
      @(posedge CLK);
      #1 cif.rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] rd; logic er; int lat;
      RST = 1'b1;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      checks++;
      if (cif.rsp_valid !== 1'b0 || cm_pc_we !== 1'b0 || cm_regfile_we !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: rsp_valid=%b pc_we=%b rf_we=%b, required 0/0/0",
                  cif.rsp_valid, cm_pc_we, cm_regfile_we);
      end
      @(posedge CLK);
      #1 RST = 1'b0;
      repeat (4) @(negedge CLK);
      checks++;
      if (cm_pc_stall !== 1'b1 || fire_cnt !== 0) begin
         errors++;
         $display("[TB] FAIL reset_halted: stall=%b fires=%0d, required 1/0", cm_pc_stall, fire_cnt);
      end
      do_cmd(4'd0, 5'd0, 32'h0, rd, er, lat);
      checks++;
      if (rd !== 32'h2 || er !== 1'b0 || lat !== 1) begin
         errors++;
         $display("[TB] FAIL reset_status: data=%h err=%b lat=%0d, required 00000002/0/1", rd, er, lat);
      end
   endtask

   task automatic test_step();
      logic [31:0] rd; logic er; int lat; int f0;
      f0 = fire_cnt;
      do_cmd(4'd3, 5'd0, 32'h0, rd, er, lat);
      checks++;
      if (er !== 1'b0 || fire_cnt - f0 !== 1) begin
         errors++;
         $display("[TB] FAIL step_once: err=%b fires=%0d, required 0/1", er, fire_cnt - f0);
      end
      checks++;
      if (cm_pc_stall !== 1'b1) begin
         errors++;
         $display("[TB] FAIL step_stall: stall=%b, required 1", cm_pc_stall);
      end
      do_cmd(4'd4, 5'd0, 32'h0, rd, er, lat);
      checks++;
      if (rd !== 32'h104 || er !== 1'b0 || lat !== 2) begin
         errors++;
         $display("[TB] FAIL step_rd_pc: data=%h err=%b lat=%0d, required 00000104/0/2", rd, er, lat);
      end
   endtask

   task automatic test_regs();
      logic [31:0] rd; logic er; int lat; int w0;
      w0 = rf_we_cnt;
      do_cmd(4'd7, 5'd5, 32'hDEADBEEF, rd, er, lat);
      checks++;
      if (er !== 1'b0 || lat !== 2 || rf_we_cnt - w0 !== 1) begin
         errors++;
         $display("[TB] FAIL wr_reg_x5: err=%b lat=%0d strobes=%0d, required 0/2/1", er, lat, rf_we_cnt - w0);
      end
      do_cmd(4'd6, 5'd5, 32'h0, rd, er, lat);
      checks++;
      if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== 2) begin
         errors++;
         $display("[TB] FAIL rd_reg_x5: data=%h err=%b lat=%0d, required deadbeef/0/2", rd, er, lat);
      end
      do_cmd(4'd7, 5'd0, 32'h1234, rd, er, lat);
      do_cmd(4'd6, 5'd0, 32'h0, rd, er, lat);
      checks++;
      if (rd !== 32'h0 || er !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rd_reg_x0: data=%h err=%b, required 00000000/0", rd, er);
      end
   endtask

   task automatic test_breakpoint();
      logic [31:0] rd; logic er; int lat; int p0;
      p0 = pc_we_cnt;
      do_cmd(4'd5, 5'd0, 32'h100, rd, er, lat);
      checks++;
      if (er !== 1'b0 || pc_we_cnt - p0 !== 1 || core_pc !== 32'h100) begin
         errors++;
         $display("[TB] FAIL wr_pc: err=%b strobes=%0d pc=%h, required 0/1/00000100", er, pc_we_cnt - p0, core_pc);
      end
      do_cmd(4'd8, 5'd0, 32'h108, rd, er, lat);
      do_cmd(4'd2, 5'd0, 32'h0, rd, er, lat);
      checks++;
      if (er !== 1'b0) begin
         errors++;
         $display("[TB] FAIL resume_ok: err=%b, required 0", er);
      end
      repeat (20) @(negedge CLK);
      do_cmd(4'd0, 5'd0, 32'h0, rd, er, lat);
      checks++;
      if (rd !== 32'h6) begin
         errors++;
         $display("[TB] FAIL bp_status: data=%h, required 00000006", rd);
      end
      do_cmd(4'd4, 5'd0, 32'h0, rd, er, lat);
      checks++;
      if (rd !== 32'h108) begin
         errors++;
         $display("[TB] FAIL bp_pc: data=%h, required 00000108", rd);
      end
      do_cmd(4'd2, 5'd0, 32'h0, rd, er, lat);
      repeat (20) @(negedge CLK);
      do_cmd(4'd1, 5'd0, 32'h0, rd, er, lat);
      do_cmd(4'd4, 5'd0, 32'h0, rd, er, lat);
      checks++;
      if (!(rd > 32'h108) || ^rd === 1'bx) begin
         errors++;
         $display("[TB] FAIL bp_pass: pc=%h, required above 00000108", rd);
      end
      do_cmd(4'd9, 5'd0, 32'h0, rd, er, lat);
      do_cmd(4'd0, 5'd0, 32'h0, rd, er, lat);
      checks++;
      if (rd !== 32'h2) begin
         errors++;
         $display("[TB] FAIL clr_bp_status: data=%h, required 00000002", rd);
      end
   endtask

   task automatic test_halt_busy();
      logic [31:0] rd; logic er; int lat; int bad;
      do_cmd(4'd2, 5'd0, 32'h0, rd, er, lat);
      repeat (3) @(negedge CLK);
      hold_busy = 1'b1;
      cif.cmd_valid = 1'b1;
      cif.cmd_op    = 4'd1;
      @(posedge CLK);
      #1 cif.cmd_valid = 1'b0;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         if (cif.rsp_valid !== 1'b0 || cm_pc_stall !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("[TB] FAIL halt_wait: %0d bad cycles, required 0 (rsp_valid low, stall high)", bad);
      end
      @(posedge CLK);
      #1 hold_busy = 1'b0;
      @(negedge CLK);
      checks++;
      if (cif.rsp_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL halt_idle_cycle: rsp_valid=%b, required 0", cif.rsp_valid);
      end
      @(negedge CLK);
      checks++;
      if (cif.rsp_valid !== 1'b1 || cif.rsp_err !== 1'b0 || cm_pc_stall !== 1'b1) begin
         errors++;
         $display("[TB] FAIL halt_rsp: valid=%b err=%b stall=%b, required 1/0/1",
                  cif.rsp_valid, cif.rsp_err, cm_pc_stall);
      end
      cif.rsp_ready = 1'b1;
      @(posedge CLK);
      #1 cif.rsp_ready = 1'b0;
      do_cmd(4'd0, 5'd0, 32'h0, rd, er, lat);
      checks++;
      if (rd !== 32'h2) begin
         errors++;
         $display("[TB] FAIL halt_status: data=%h, required 00000002", rd);
      end
   endtask

   task automatic test_illegal_access();
      logic [31:0] rd; logic er1, er2, er3; int lat; int w0, p0;
      do_cmd(4'd2, 5'd0, 32'h0, rd, er1, lat);
      repeat (2) @(negedge CLK);
      w0 = rf_we_cnt;
      p0 = pc_we_cnt;
      do_cmd(4'd6, 5'd5, 32'h0, rd, er1, lat);
      do_cmd(4'd7, 5'd5, 32'h11111111, rd, er2, lat);
      do_cmd(4'd5, 5'd0, 32'h400, rd, er3, lat);
      checks++;
      if (er1 !== 1'b1 || er2 !== 1'b1 || er3 !== 1'b1 || rf_we_cnt != w0 || pc_we_cnt != p0) begin
         errors++;
         $display("[TB] FAIL running_access: err=%b%b%b strobes=%0d/%0d, required 111 and 0/0",
                  er1, er2, er3, rf_we_cnt - w0, pc_we_cnt - p0);
      end
      do_cmd(4'd1, 5'd0, 32'h0, rd, er1, lat);
      do_cmd(4'd6, 5'd5, 32'h0, rd, er1, lat);
      checks++;
      if (rd !== 32'hDEADBEEF || er1 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL x5_intact: data=%h err=%b, required deadbeef/0", rd, er1);
      end
   endtask

   task automatic test_step_timeout();
      logic [31:0] rd; logic er; int lat; int f0;
      block_fire = 1'b1;
      f0 = fire_cnt;
      do_cmd(4'd3, 5'd0, 32'h0, rd, er, lat);
      checks++;
      if (er !== 1'b1 || lat !== TMO + 1 || fire_cnt != f0) begin
         errors++;
         $display("[TB] FAIL step_timeout: err=%b lat=%0d fires=%0d, required 1/%0d/0", er, lat, fire_cnt - f0, TMO + 1);
      end
      do_cmd(4'd0, 5'd0, 32'h0, rd, er, lat);
      checks++;
      if (rd !== 32'h2) begin
         errors++;
         $display("[TB] FAIL timeout_status: data=%h, required 00000002", rd);
      end
      block_fire = 1'b0;
      do_cmd(4'hF, 5'd0, 32'h0, rd, er, lat);
      checks++;
      if (er !== 1'b1 || lat !== 1) begin
         errors++;
         $display("[TB] FAIL bad_op: err=%b lat=%0d, required 1/1", er, lat);
      end
      do_cmd(4'd0, 5'd0, 32'h0, rd, er, lat);
      checks++;
      if (rd !== 32'h2 || er !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bad_op_status: data=%h err=%b, required 00000002/0", rd, er);
      end
   endtask

   task automatic test_reset_midop();
      logic [31:0] rd; logic er; int lat; int p0, w0;
      do_cmd(4'd8, 5'd0, 32'h300, rd, er, lat);
      block_fire = 1'b1;
      @(negedge CLK);
      cif.cmd_valid = 1'b1;
      cif.cmd_op    = 4'd3;
      @(posedge CLK);
      #1 cif.cmd_valid = 1'b0;
      repeat (3) @(posedge CLK);
      #1 RST = 1'b1;
      p0 = pc_we_cnt;
      w0 = rf_we_cnt;
      @(negedge CLK);
      checks++;
      if (cif.rsp_valid !== 1'b0 || cif.cmd_ready !== 1'b1 || cm_pc_stall !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midop_reset: rsp_valid=%b cmd_ready=%b stall=%b, required 0/1/1",
                  cif.rsp_valid, cif.cmd_ready, cm_pc_stall);
      end
      @(posedge CLK);
      #1 RST = 1'b0;
      block_fire = 1'b0;
      repeat (TMO + 4) @(negedge CLK);
      checks++;
      if (cif.rsp_valid !== 1'b0 || pc_we_cnt != p0 || rf_we_cnt != w0) begin
         errors++;
         $display("[TB] FAIL midop_quiet: rsp_valid=%b strobes=%0d/%0d, required 0 and 0/0",
                  cif.rsp_valid, pc_we_cnt - p0, rf_we_cnt - w0);
      end
      do_cmd(4'd0, 5'd0, 32'h0, rd, er, lat);
      checks++;
      if (rd !== 32'h2) begin
         errors++;
         $display("[TB] FAIL midop_status: data=%h, required 00000002", rd);
      end
   endtask

   initial begin
      RST           = 1'b1;
      hold_busy     = 1'b0;
      block_fire    = 1'b0;
      cif.cmd_valid = 1'b0;
      cif.cmd_op    = 4'd0;
      cif.cmd_addr  = 5'd0;
      cif.cmd_data  = 32'h0;
      cif.rsp_ready = 1'b0;
      test_reset();
      test_step();
      test_regs();
      test_breakpoint();
      test_halt_busy();
      test_illegal_access();
      test_step_timeout();
      test_reset_midop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
